// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and sizes for the tagged memory interface
package mem_resp_pkg;

    localparam int XLEN        = 32;
    localparam int MEM_DEPTH   = 4;
    localparam int MEM_LATENCY = 4;
    localparam int MEM_ROWS    = 1024;

    // Bits needed to index n distinct values (never less than 1).
    function automatic int idx_len(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int MEM_TAG_W = idx_len(MEM_DEPTH + 1);
    // Room for LATENCY-1 plus up to 3 cycles of optional jitter.
    localparam int MEM_CD_W  = idx_len(MEM_LATENCY + 4);
    localparam int MEM_ROW_W = idx_len(MEM_ROWS);
    localparam int MEM_IDX_W = XLEN - 2;

    typedef enum logic [1:0] {
        MEM_CMD_NONE  = 2'd0,
        MEM_CMD_LOAD  = 2'd1,
        MEM_CMD_STORE = 2'd2
    } mem_cmd_t;

    typedef logic [XLEN-1:0]      mem_blk_t;
    typedef logic [MEM_TAG_W-1:0] mem_tag_t;
    typedef logic [MEM_CD_W-1:0]  mem_cd_t;
    typedef logic [MEM_ROW_W-1:0] mem_row_t;
    typedef logic [MEM_IDX_W-1:0] mem_idx_t;

    typedef struct packed {
        mem_tag_t tag;
        mem_cmd_t cmd;
        mem_row_t row;
        mem_blk_t blk;
        mem_cd_t  cd;
    } mem_pend_t;

endpackage

// File: rtl/mem_resp_if.sv
// rtl/mem_resp_if.sv - memory request/answer interface between a cache and its responder
// Signals: qry_cmd/qry_idx/qry_blk (request), ack (same-cycle tag grant),
//          ans_tag/ans_blk (registered answer). Modports: initiator, responder.
interface mem_resp_if;
    import mem_resp_pkg::*;

    mem_cmd_t qry_cmd;
    mem_idx_t qry_idx;
    mem_blk_t qry_blk;
    mem_tag_t ack;
    mem_tag_t ans_tag;
    mem_blk_t ans_blk;

    modport initiator (
        output qry_cmd, qry_idx, qry_blk,
        input  ack, ans_tag, ans_blk
    );

    modport responder (
        input  qry_cmd, qry_idx, qry_blk,
        output ack, ans_tag, ans_blk
    );
endinterface

// File: rtl/mem_resp_pend_q.sv
// rtl/mem_resp_pend_q.sv - in-order pending-request FIFO with per-entry latency countdown
// Ports: clock, reset (sync, active-low), push/push_entry (tail write),
//        pop (head release), head (head entry), pop_ready (head due), empty.
module mem_pend_q
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  mem_pend_t push_entry,
    input  logic      pop,
    output mem_pend_t head,
    output logic      pop_ready,
    output logic      empty
);
    localparam int PTR_W = idx_len(DEPTH);
    localparam int CNT_W = idx_len(DEPTH + 1);

    mem_pend_t        ent [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head  = ent[rd_ptr];
    assign empty = (count == '0);
    // The answer register adds one cycle after the pop, so the head is released
    // while its countdown still reads 1; entries held behind a slower head sit at 0.
    assign pop_ready = !empty && (head.cd <= mem_cd_t'(1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage is not reset: stale slots are invisible once count is cleared.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_ptr == PTR_W'(i)) begin
                ent[i] <= push_entry;
            end else if (ent[i].cd != '0) begin
                ent[i].cd <= ent[i].cd - mem_cd_t'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(push && !pop && count == CNT_W'(DEPTH)));
            assert (!(pop && empty));
        end
    end
endmodule

// File: rtl/mem_resp.sv
// rtl/mem_resp.sv - tagged in-order memory responder with fixed (optionally jittered) latency
// Ports: clock, reset (sync, active-low), memory (mem_resp_if.responder).
// Optional build macro MEM_JITTER_EN: adds 0..3 cycles of LFSR-driven latency per request.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = MEM_DEPTH,
    parameter int LATENCY = MEM_LATENCY,
    parameter int ROWS    = MEM_ROWS
) (
    input  logic          clock,
    input  logic          reset,
    mem_resp_if.responder memory
);
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] clr_mask;
    mem_tag_t         grant_tag;
    mem_tag_t         ans_tag_q;
    mem_blk_t         ans_blk_q;
    logic             accept;
    logic             bypass;
    logic             push;
    logic             pop;
    logic             pop_ready;
    logic             q_empty;
    logic             do_ans;
    mem_cd_t          extra;
    mem_pend_t        new_entry;
    mem_pend_t        head;
    mem_pend_t        src;
    mem_blk_t         store [ROWS];
    logic             unused_idx_hi;

    // Rows alias: address bits above the row index are ignored.
    assign unused_idx_hi = ^memory.qry_idx[MEM_IDX_W-1:MEM_ROW_W];

    // Lowest free tag wins.
    always_comb begin
        grant_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) grant_tag = mem_tag_t'(i + 1);
        end
    end

    assign accept     = reset && (memory.qry_cmd != MEM_CMD_NONE) && (grant_tag != '0);
    assign memory.ack = accept ? grant_tag : '0;

    // A tag is released the cycle after it is presented on ans_tag, so an accept in
    // the answer cycle can never be handed the tag still being answered.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && grant_tag == mem_tag_t'(i + 1)) set_mask[i] = 1'b1;
            if (ans_tag_q == mem_tag_t'(i + 1))           clr_mask[i] = 1'b1;
        end
    end

`ifdef MEM_JITTER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr <= 16'hACE1;
        end else if (accept) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign extra = mem_cd_t'(lfsr[1:0]);
`else
    assign extra = '0;
`endif

    always_comb begin
        new_entry     = '0;
        new_entry.tag = grant_tag;
        new_entry.cmd = memory.qry_cmd;
        new_entry.row = memory.qry_idx[MEM_ROW_W-1:0];
        new_entry.blk = memory.qry_blk;
        new_entry.cd  = mem_cd_t'(LATENCY - 1) + extra;
    end

    // A one-cycle request cannot wait in the queue and still answer next cycle,
    // so with nothing ahead of it it goes straight to the answer stage.
    assign bypass = accept && q_empty && (LATENCY == 1) && (extra == '0);
    assign push   = accept && !bypass;
    assign pop    = pop_ready;
    assign do_ans = bypass || pop;
    assign src    = bypass ? new_entry : head;

    mem_pend_q #(
        .DEPTH (DEPTH)
    ) u_pend_q (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (new_entry),
        .pop        (pop),
        .head       (head),
        .pop_ready  (pop_ready),
        .empty      (q_empty)
    );

    // Accesses happen at release, in acceptance order, which gives program-order
    // read-after-write without any forwarding.
    always_ff @(posedge clock) begin
        if (reset && do_ans && src.cmd == MEM_CMD_STORE) begin
            store[src.row] <= src.blk;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy      <= '0;
            ans_tag_q <= '0;
            ans_blk_q <= '0;
        end else begin
            busy <= (busy | set_mask) & ~clr_mask;
            if (do_ans) begin
                ans_tag_q <= src.tag;
                ans_blk_q <= (src.cmd == MEM_CMD_LOAD) ? store[src.row] : '0;
            end else begin
                ans_tag_q <= '0;
                ans_blk_q <= '0;
            end
        end
    end

    assign memory.ans_tag = ans_tag_q;
    assign memory.ans_blk = ans_blk_q;

    always_ff @(posedge clock) begin
        assert (LATENCY >= 1);
        assert (DEPTH >= 1);
        assert (DEPTH + 1 <= (1 << MEM_TAG_W));
        assert (LATENCY + 3 <= (1 << MEM_CD_W));
        if (reset && ans_tag_q != '0) begin
            assert ((clr_mask & busy) != '0);
        end
    end
endmodule

// File: tb/tb_mem_resp.sv
// tb/tb_mem_resp.sv - self-checking bench for mem_resp with a queue-based reference model
module tb_mem_resp;
    import mem_resp_pkg::*;

    localparam int L = MEM_LATENCY;
    localparam int D = MEM_DEPTH;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_resp_if bus ();

    mem_resp dut (
        .clock  (clock),
        .reset  (reset),
        .memory (bus)
    );

    typedef struct {
        int          tag;
        mem_cmd_t    cmd;
        int          row;
        logic [31:0] blk;
        int          due;
    } req_t;

    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    req_t        pend[$];
    bit          busy_m [1:D];
    int          last_ans = 0;
    int          last_due = 0;
    logic [31:0] mem_m [int];
    logic [15:0] lfsr_m   = 16'hACE1;
    int          obs_ack;
    logic [31:0] obs_tag;
    logic [31:0] obs_blk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", name, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive request, compare against the model, advance the model.
    task automatic step(input logic rst_n, input mem_cmd_t cmd, input mem_idx_t idx,
                        input logic [31:0] blk);
        int          exp_ack;
        int          exp_tag;
        logic [31:0] exp_blk;
        int          extra;
        int          due;
        req_t        r;
        reset       = rst_n;
        bus.qry_cmd = cmd;
        bus.qry_idx = idx;
        bus.qry_blk = blk;
        @(negedge clock);
        if (last_ans != 0) busy_m[last_ans] = 1'b0;
        last_ans = 0;
        exp_tag  = 0;
        exp_blk  = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r        = pend.pop_front();
            exp_tag  = r.tag;
            last_ans = r.tag;
            if (r.cmd == MEM_CMD_LOAD) exp_blk = mem_m[r.row];
            else mem_m[r.row] = r.blk;
        end
        exp_ack = 0;
        if (rst_n && cmd != MEM_CMD_NONE) begin
            for (int t = D; t >= 1; t--) if (!busy_m[t]) exp_ack = t;
        end
        obs_ack = int'(bus.ack);
        obs_tag = 32'(bus.ans_tag);
        obs_blk = bus.ans_blk;
        chk("ack", obs_tag == obs_tag ? 32'(bus.ack) : 32'(bus.ack), 32'(exp_ack));
        chk("ans_tag", obs_tag, 32'(exp_tag));
        chk("ans_blk", obs_blk, exp_blk);
        if (exp_ack != 0) begin
            extra = 0;
`ifdef MEM_JITTER_EN
            extra  = int'(lfsr_m[1:0]);
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
            busy_m[exp_ack] = 1'b1;
            due = cyc + L + extra;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.tag = exp_ack;
            r.cmd = cmd;
            r.row = int'(idx[MEM_ROW_W-1:0]);
            r.blk = blk;
            r.due = due;
            pend.push_back(r);
        end
        if (!rst_n) begin
            pend.delete();
            for (int t = 1; t <= D; t++) busy_m[t] = 1'b0;
            last_ans = 0;
            last_due = 0;
            lfsr_m   = 16'hACE1;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, MEM_CMD_NONE, '0, '0);
    endtask

    initial begin
        int          acks [6];
        bit          known [48];
        bit          have;
        mem_cmd_t    rcmd;
        mem_idx_t    ridx;
        logic [31:0] rblk;
        int          row;
        logic [19:0] hi;

        bus.qry_cmd = MEM_CMD_NONE;
        bus.qry_idx = '0;
        bus.qry_blk = '0;
        @(posedge clock);
        #1;

        // Reset state: no grant even with a request present.
        step(1'b0, MEM_CMD_NONE, '0, '0);
        step(1'b0, MEM_CMD_LOAD, 30'd5, '0);
        chk("rst_ack", 32'(obs_ack), 32'd0);

        // Single STORE then LOAD of the same row.
        step(1'b1, MEM_CMD_STORE, 30'd5, 32'hDEADBEEF);
        idle(5);
        step(1'b1, MEM_CMD_LOAD, 30'd5, '0);
`ifndef MEM_JITTER_EN
        chk("t1_ack", 32'(obs_ack), 32'd1);
        idle(3);
        idle(1);
        chk("t1_tag", obs_tag, 32'd1);
        chk("t1_blk", obs_blk, 32'hDEADBEEF);
`endif
        idle(4);

        // STORE followed directly by a LOAD of the same row.
        step(1'b1, MEM_CMD_STORE, 30'd7, 32'h0000_1234);
        step(1'b1, MEM_CMD_LOAD, 30'd7, '0);
        idle(6);

        // Back-to-back loads exhaust the tag pool; tag 1 returns the cycle after its answer.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, MEM_CMD_LOAD, (i % 2 == 0) ? 30'd5 : 30'd7, '0);
            acks[i] = obs_ack;
        end
`ifndef MEM_JITTER_EN
        chk("t3_ack0", 32'(acks[0]), 32'd1);
        chk("t3_ack1", 32'(acks[1]), 32'd2);
        chk("t3_ack2", 32'(acks[2]), 32'd3);
        chk("t3_ack3", 32'(acks[3]), 32'd4);
        chk("t3_ack4", 32'(acks[4]), 32'd0);
        chk("t3_ack5", 32'(acks[5]), 32'd1);
`endif
        idle(10);

        // Reset with requests in flight: pending store to row 9 must be dropped.
        step(1'b1, MEM_CMD_STORE, 30'd9, 32'h9999_0000);
        idle(6);
        step(1'b1, MEM_CMD_STORE, 30'd9, 32'h0000_0BAD);
        step(1'b1, MEM_CMD_LOAD, 30'd7, '0);
        step(1'b1, MEM_CMD_LOAD, 30'd5, '0);
        step(1'b0, MEM_CMD_NONE, '0, '0);
        idle(6);
        step(1'b1, MEM_CMD_LOAD, 30'd9, '0);
`ifndef MEM_JITTER_EN
        chk("t5_ack", 32'(obs_ack), 32'd1);
        idle(4);
        chk("t5_blk", obs_blk, 32'h9999_0000);
`endif
        idle(6);

        // Random traffic with aliased upper address bits; refused requests are re-presented.
        have = 1'b0;
        rcmd = MEM_CMD_NONE;
        ridx = '0;
        rblk = '0;
        row  = 32;
        for (int n = 0; n < 400; n++) begin
            if (!have) begin
                if ($urandom_range(3) == 0) begin
                    rcmd = MEM_CMD_NONE;
                end else begin
                    row  = 32 + int'($urandom_range(15));
                    hi   = 20'($urandom);
                    ridx = {hi, 10'(row)};
                    rblk = $urandom;
                    rcmd = (!known[row] || $urandom_range(1) == 1) ? MEM_CMD_STORE : MEM_CMD_LOAD;
                    have = 1'b1;
                end
            end
            step(1'b1, rcmd, ridx, rblk);
            if (have && obs_ack != 0) begin
                if (rcmd == MEM_CMD_STORE) known[row] = 1'b1;
                have = 1'b0;
                rcmd = MEM_CMD_NONE;
            end
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
